// File: rtl/uart_pkg.sv
// Shared UART constants and the command-assembly FSM state type.
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } wr_state_e;

endpackage

// File: rtl/uart.sv
// 8N1 serial engine: independent transmitter and receiver sharing BAUD_DIV timing.
module uart
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 5208
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_i,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 trmt_i,
  output logic                 tx_o,
  output logic                 tx_done_o,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_rdy_o
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2);
  localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_BITS - 1);

  logic [FRAME_BITS-1:0] tx_shift_q;
  logic [CW-1:0]         tx_baud_q;
  logic [BW-1:0]         tx_bit_q;
  logic                  tx_busy_q;
  logic                  tx_done_q;

  // The idle line is the all-ones shift register, so TX needs no extra mux.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift_q <= '1;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
    end else if (!tx_busy_q) begin
      if (trmt_i) begin
        tx_shift_q <= {1'b1, tx_data_i, 1'b0};
        tx_baud_q  <= '0;
        tx_bit_q   <= '0;
        tx_busy_q  <= 1'b1;
        tx_done_q  <= 1'b0;
      end
    end else if (tx_baud_q == BAUD_LAST) begin
      tx_baud_q  <= '0;
      tx_shift_q <= {1'b1, tx_shift_q[FRAME_BITS-1:1]};
      if (tx_bit_q == BIT_LAST) begin
        tx_bit_q  <= '0;
        tx_busy_q <= 1'b0;
        tx_done_q <= 1'b1;
      end else begin
        tx_bit_q <= tx_bit_q + 1'b1;
      end
    end else begin
      tx_baud_q <= tx_baud_q + 1'b1;
    end
  end

  assign tx_o      = tx_shift_q[0];
  assign tx_done_o = tx_done_q;

  logic [1:0]           rx_sync_q;
  logic                 rx_prev_q;
  logic [CW-1:0]        rx_baud_q;
  logic [BW-1:0]        rx_bit_q;
  logic                 rx_busy_q;
  logic                 rx_rdy_q;
  logic [DATA_BITS-1:0] rx_shift_q;

  // Synchroniser and edge history preset high so reset release never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync_q  <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_busy_q  <= 1'b0;
      rx_rdy_q   <= 1'b0;
      rx_shift_q <= '0;
    end else begin
      rx_sync_q <= {rx_sync_q[0], rx_i};
      rx_prev_q <= rx_sync_q[1];
      rx_rdy_q  <= 1'b0;
      if (!rx_busy_q) begin
        if (rx_prev_q && !rx_sync_q[1]) begin
          rx_busy_q <= 1'b1;
          rx_baud_q <= '0;
          rx_bit_q  <= '0;
        end
      end else begin
        rx_baud_q <= (rx_baud_q == BAUD_LAST) ? '0 : rx_baud_q + 1'b1;
        if (rx_baud_q == BAUD_HALF) begin
          if (rx_bit_q == BIT_LAST) begin
            rx_bit_q  <= '0;
            rx_busy_q <= 1'b0;
            rx_rdy_q  <= 1'b1;
          end else begin
            if (rx_bit_q != '0)
              rx_shift_q <= {rx_sync_q[1], rx_shift_q[DATA_BITS-1:1]};
            rx_bit_q <= rx_bit_q + 1'b1;
          end
        end
      end
    end
  end

  assign rx_data_o = rx_shift_q;
  assign rx_rdy_o  = rx_rdy_q;

endmodule

// File: rtl/uart_wrapper.sv
// Assembles two received bytes into a 16-bit command and transmits response bytes.
// Optional inter-byte timeout enabled by defining CMD_TIMEOUT_EN.
module uart_wrapper
  import uart_pkg::*;
#(
  parameter int BAUD_DIV    = 5208,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done
);

  logic                 rx_rdy;
  logic [DATA_BITS-1:0] rx_data;

  uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk       (clk),
    .rst       (rst),
    .rx_i      (RX),
    .tx_data_i (resp),
    .trmt_i    (trmt),
    .tx_o      (TX),
    .tx_done_o (tx_done),
    .rx_data_o (rx_data),
    .rx_rdy_o  (rx_rdy)
  );

  wr_state_e            state_q;
  logic [DATA_BITS-1:0] high_q;
  logic [15:0]          cmd_q;
  logic                 cmd_rdy_q;

`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tmo_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      high_q    <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      // Acknowledge first so a same-cycle set below takes priority.
      if (clr_cmd_rdy)
        cmd_rdy_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx_rdy) begin
            high_q    <= rx_data;
            cmd_rdy_q <= 1'b0;
            state_q   <= HIGH;
          end
        end
        HIGH: begin
          state_q <= LOW;
`ifdef CMD_TIMEOUT_EN
          tmo_q   <= '0;
`endif
        end
        LOW: begin
          if (rx_rdy) begin
            cmd_q     <= {high_q, rx_data};
            cmd_rdy_q <= 1'b1;
            state_q   <= IDLE;
          end
`ifdef CMD_TIMEOUT_EN
          else if (tmo_q == TMO_LAST) begin
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;

endmodule

// File: tb/tb_uart_wrapper.sv
// Directed bench for uart_wrapper: command assembly, response transmit, reset and timeout.
module tb_uart_wrapper;

  localparam int BD  = 16;
  localparam int TMO = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        RX;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        trmt;
  logic        tx_done;

  int checks = 0;
  int errors = 0;
  int done_rises = 0;
  logic done_prev = 1'b0;

  always #5 clk = ~clk;

  uart_wrapper #(.BAUD_DIV(BD), .TIMEOUT_CYC(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .trmt        (trmt),
    .tx_done     (tx_done)
  );

  always @(posedge clk) begin
    done_prev <= tx_done;
    if (tx_done && !done_prev) done_rises <= done_rises + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives start and data bits, then leaves the line high for the stop bit.
  task automatic send_byte(input logic [7:0] b);
    RX = 1'b0;
    tick(BD);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      tick(BD);
    end
    RX = 1'b1;
  endtask

  task automatic wait_rdy();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * BD && !seen; i++) begin
      tick(1);
      seen = dut.rx_rdy;
    end
    check("rx_rdy_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic recv_high(input logic [7:0] hi);
    send_byte(hi);
    wait_rdy();
    tick(1);
    check("high_clears_rdy", {31'd0, cmd_rdy}, 32'd0);
    tick(BD);
  endtask

  task automatic recv_low(input logic [7:0] lo, input logic [15:0] exp, input logic hold_clr);
    clr_cmd_rdy = hold_clr;
    send_byte(lo);
    wait_rdy();
    check("rdy_before_set", {31'd0, cmd_rdy}, 32'd0);
    tick(1);
    check("rdy_set", {31'd0, cmd_rdy}, 32'd1);
    check("cmd_value", {16'd0, cmd}, {16'd0, exp});
    if (hold_clr) begin
      tick(1);
      check("clr_after_set", {31'd0, cmd_rdy}, 32'd0);
      clr_cmd_rdy = 1'b0;
    end
    tick(BD);
  endtask

  // frame holds the hand-computed wire bits, bit 0 first on the line.
  task automatic tx_frame(input logic [7:0] v, input logic [9:0] frame, input logic inject);
    int rises0;
    int gap;
    resp = v;
    trmt = 1'b1;
    tick(1);
    trmt = 1'b0;
    rises0 = done_rises;
    check("tx_done_cleared", {31'd0, tx_done}, 32'd0);
    tick(BD / 2);
    check("tx_bit0", {31'd0, TX}, {31'd0, frame[0]});
    gap = BD;
    for (int k = 1; k < 10; k++) begin
      tick(gap);
      gap = BD;
      check($sformatf("tx_bit%0d", k), {31'd0, TX}, {31'd0, frame[k]});
      if (inject && k == 4) begin
        resp = 8'h00;
        trmt = 1'b1;
        tick(1);
        trmt = 1'b0;
        gap = BD - 1;
      end
    end
    check("tx_done_in_stop", {31'd0, tx_done}, 32'd0);
    tick(BD / 2 - 1);
    check("tx_done_before_end", {31'd0, tx_done}, 32'd0);
    tick(1);
    check("tx_done_at_end", {31'd0, tx_done}, 32'd1);
    tick(2 * BD);
    check("tx_idle_high", {31'd0, TX}, 32'd1);
    check("tx_done_held", {31'd0, tx_done}, 32'd1);
    check("tx_done_rises_once", done_rises - rises0, 32'd1);
  endtask

  initial begin
    logic [7:0] partial;
    rst = 1'b1;
    RX = 1'b1;
    trmt = 1'b0;
    clr_cmd_rdy = 1'b0;
    resp = 8'h00;
    tick(3);
    check("rst_tx", {31'd0, TX}, 32'd1);
    check("rst_cmd", {16'd0, cmd}, 32'd0);
    check("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    check("rst_tx_done", {31'd0, tx_done}, 32'd0);
    rst = 1'b0;
    tick(2 * BD);

    recv_high(8'h42);
    recv_low(8'h31, 16'h4231, 1'b0);
    check("rdy_held", {31'd0, cmd_rdy}, 32'd1);
    clr_cmd_rdy = 1'b1;
    tick(1);
    clr_cmd_rdy = 1'b0;
    check("clr_drops_rdy", {31'd0, cmd_rdy}, 32'd0);
    check("clr_keeps_cmd", {16'd0, cmd}, 32'h4231);

    tx_frame(8'hA5, 10'b1101001010, 1'b0);
    tx_frame(8'hA5, 10'b1101001010, 1'b1);

    fork
      begin
        recv_high(8'h43);
        recv_low(8'h21, 16'h4321, 1'b0);
      end
      tx_frame(8'h5A, 10'b1010110100, 1'b0);
    join

    // Reset mid-frame while both directions are busy.
    resp = 8'h00;
    trmt = 1'b1;
    tick(1);
    trmt = 1'b0;
    partial = 8'h12;
    RX = 1'b0;
    tick(BD);
    for (int i = 0; i < 4; i++) begin
      RX = partial[i];
      tick(BD);
    end
    RX = partial[4];
    tick(BD / 2);
    rst = 1'b1;
    #1;
    check("midrst_tx", {31'd0, TX}, 32'd1);
    check("midrst_cmd", {16'd0, cmd}, 32'd0);
    check("midrst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    check("midrst_tx_done", {31'd0, tx_done}, 32'd0);
    RX = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2 * BD);
    check("post_rst_no_rdy", {31'd0, cmd_rdy}, 32'd0);
    recv_high(8'h12);
    recv_low(8'h34, 16'h1234, 1'b1);

    recv_high(8'h77);
    tick(1500);
`ifdef CMD_TIMEOUT_EN
    check("timeout_keeps_cmd", {16'd0, cmd}, 32'h1234);
    recv_high(8'h11);
    recv_low(8'h22, 16'h1122, 1'b0);
`else
    recv_low(8'h11, 16'h7711, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
